// File: rtl/stg_mo_pipe.sv
// Memory-operation pipeline stage between execute and writeback.
// Issues load/store requests over a req/ack handshake with timeout; other ops pass through in one cycle.
module stg_mo_pipe #(
   parameter int unsigned      W_ADDR   = 24,
   parameter int unsigned      W_DATA   = 24,
   parameter int unsigned      W_OPC    = 8,
   parameter int unsigned      W_TGT_GP = 4,
   parameter int unsigned      W_TGT_SR = 2,
   parameter logic [W_OPC-1:0] OPC_LD   = W_OPC'(8'h10),
   parameter logic [W_OPC-1:0] OPC_ST   = W_OPC'(8'h11),
   parameter int unsigned      TIMEOUT  = 15
) (
   input  logic                iw_clk,
   input  logic                iw_rst,
   input  logic                iw_valid,
   output logic                ow_ready,
   input  logic                iw_flush,
   input  logic [W_ADDR-1:0]   iw_pc,
   input  logic [W_DATA-1:0]   iw_instr,
   input  logic [W_OPC-1:0]    iw_opc,
   input  logic [W_DATA-1:0]   iw_result,
   input  logic [W_DATA-1:0]   iw_src_data,
   input  logic [W_TGT_GP-1:0] iw_tgt_gp,
   input  logic                iw_tgt_gp_we,
   input  logic [W_TGT_SR-1:0] iw_tgt_sr,
   input  logic                iw_tgt_sr_we,
   output logic                ow_valid,
   input  logic                iw_ready,
   output logic [W_ADDR-1:0]   ow_pc,
   output logic [W_DATA-1:0]   ow_instr,
   output logic [W_OPC-1:0]    ow_opc,
   output logic [W_DATA-1:0]   ow_result,
   output logic [W_TGT_GP-1:0] ow_tgt_gp,
   output logic                ow_tgt_gp_we,
   output logic [W_TGT_SR-1:0] ow_tgt_sr,
   output logic                ow_tgt_sr_we,
   output logic                ow_mem_req,
   output logic                ow_mem_we,
   output logic [W_ADDR-1:0]   ow_mem_addr,
   output logic [W_DATA-1:0]   ow_mem_wdata,
   input  logic                iw_mem_ack,
   input  logic [W_DATA-1:0]   iw_mem_rdata,
   output logic                ow_mem_err
);

   localparam int unsigned W_CNT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [W_CNT-1:0]    cnt_q, cnt_d;
   logic [W_ADDR-1:0]   pc_q, pc_d;
   logic [W_DATA-1:0]   instr_q, instr_d;
   logic [W_OPC-1:0]    opc_q, opc_d;
   logic [W_DATA-1:0]   result_q, result_d;
   logic [W_ADDR-1:0]   addr_q, addr_d;
   logic [W_DATA-1:0]   wdata_q, wdata_d;
   logic [W_TGT_GP-1:0] gp_q, gp_d;
   logic                gp_we_q, gp_we_d;
   logic [W_TGT_SR-1:0] sr_q, sr_d;
   logic                sr_we_q, sr_we_d;
   logic                valid_q, valid_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic                err_q, err_d;
   logic                gp_we_o_q, gp_we_o_d;
   logic                sr_we_o_q, sr_we_o_d;

   logic ready_c, accept_c, is_mem_c;

   assign ready_c  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & iw_ready);
   assign accept_c = iw_valid & ready_c & ~iw_flush;
   assign is_mem_c = (iw_opc == OPC_LD) | (iw_opc == OPC_ST);

   // Next-state and field update; flush overrides everything including a same-cycle ack.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      opc_d    = opc_q;
      result_d = result_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      gp_d     = gp_q;
      gp_we_d  = gp_we_q;
      sr_d     = sr_q;
      sr_we_d  = sr_we_q;
      err_d    = 1'b0;

      if (iw_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_MEM: begin
               if (iw_mem_ack) begin
                  if (opc_q == OPC_LD) begin
                     result_d = iw_mem_rdata;
                  end
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + W_CNT'(1);
                  // Abandon the request: entry retires without register writes.
                  if (cnt_d == W_CNT'(TIMEOUT)) begin
                     state_d = ST_HOLD;
                     err_d   = 1'b1;
                     gp_we_d = 1'b0;
                     sr_we_d = 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (iw_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (accept_c) begin
            pc_d     = iw_pc;
            instr_d  = iw_instr;
            opc_d    = iw_opc;
            result_d = iw_result;
            addr_d   = W_ADDR'(iw_result);
            wdata_d  = iw_src_data;
            gp_d     = iw_tgt_gp;
            gp_we_d  = iw_tgt_gp_we;
            sr_d     = iw_tgt_sr;
            sr_we_d  = iw_tgt_sr_we;
            cnt_d    = '0;
            state_d  = is_mem_c ? ST_MEM : ST_HOLD;
         end
      end

      // Registered status outputs follow the next state.
      valid_d   = (state_d == ST_HOLD);
      req_d     = (state_d == ST_MEM);
      we_d      = req_d & (opc_d == OPC_ST);
      gp_we_o_d = valid_d & gp_we_d;
      sr_we_o_d = valid_d & sr_we_d;
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pc_q      <= '0;
         instr_q   <= '0;
         opc_q     <= '0;
         result_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         gp_q      <= '0;
         gp_we_q   <= 1'b0;
         sr_q      <= '0;
         sr_we_q   <= 1'b0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         gp_we_o_q <= 1'b0;
         sr_we_o_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         opc_q     <= opc_d;
         result_q  <= result_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         gp_q      <= gp_d;
         gp_we_q   <= gp_we_d;
         sr_q      <= sr_d;
         sr_we_q   <= sr_we_d;
         valid_q   <= valid_d;
         req_q     <= req_d;
         we_q      <= we_d;
         err_q     <= err_d;
         gp_we_o_q <= gp_we_o_d;
         sr_we_o_q <= sr_we_o_d;
      end
   end

   assign ow_ready     = ready_c;
   assign ow_valid     = valid_q;
   assign ow_pc        = pc_q;
   assign ow_instr     = instr_q;
   assign ow_opc       = opc_q;
   assign ow_result    = result_q;
   assign ow_tgt_gp    = gp_q;
   assign ow_tgt_gp_we = gp_we_o_q;
   assign ow_tgt_sr    = sr_q;
   assign ow_tgt_sr_we = sr_we_o_q;
   assign ow_mem_req   = req_q;
   assign ow_mem_we    = we_q;
   assign ow_mem_addr  = addr_q;
   assign ow_mem_wdata = wdata_q;
   assign ow_mem_err   = err_q;

endmodule

// File: tb/tb_stg_mo_pipe.sv
// Bench for stg_mo_pipe: directed scenarios plus a randomized run against a transaction-level model.
module tb_stg_mo_pipe;
   localparam int unsigned TMO = 15;
   localparam logic [7:0] OPC_LD = 8'h10;
   localparam logic [7:0] OPC_ST = 8'h11;

   logic        iw_clk, iw_rst, iw_valid, ow_ready, iw_flush;
   logic [23:0] iw_pc, iw_instr, iw_result, iw_src_data;
   logic [7:0]  iw_opc;
   logic [3:0]  iw_tgt_gp;
   logic        iw_tgt_gp_we;
   logic [1:0]  iw_tgt_sr;
   logic        iw_tgt_sr_we;
   logic        ow_valid, iw_ready;
   logic [23:0] ow_pc, ow_instr, ow_result;
   logic [7:0]  ow_opc;
   logic [3:0]  ow_tgt_gp;
   logic        ow_tgt_gp_we;
   logic [1:0]  ow_tgt_sr;
   logic        ow_tgt_sr_we;
   logic        ow_mem_req, ow_mem_we;
   logic [23:0] ow_mem_addr, ow_mem_wdata;
   logic        iw_mem_ack;
   logic [23:0] iw_mem_rdata;
   logic        ow_mem_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] pc, instr, result, addr, wdata;
      logic [7:0]  opc;
      logic [3:0]  gp;
      logic        gp_we;
      logic [1:0]  sr;
      logic        sr_we;
      bit          is_st;
   } ent_t;

   stg_mo_pipe #(
      .W_ADDR(24), .W_DATA(24), .W_OPC(8), .W_TGT_GP(4), .W_TGT_SR(2),
      .OPC_LD(8'h10), .OPC_ST(8'h11), .TIMEOUT(15)
   ) dut (
      .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_valid(iw_valid), .ow_ready(ow_ready),
      .iw_flush(iw_flush), .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
      .iw_result(iw_result), .iw_src_data(iw_src_data), .iw_tgt_gp(iw_tgt_gp),
      .iw_tgt_gp_we(iw_tgt_gp_we), .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we),
      .ow_valid(ow_valid), .iw_ready(iw_ready), .ow_pc(ow_pc), .ow_instr(ow_instr),
      .ow_opc(ow_opc), .ow_result(ow_result), .ow_tgt_gp(ow_tgt_gp),
      .ow_tgt_gp_we(ow_tgt_gp_we), .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
      .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr),
      .ow_mem_wdata(ow_mem_wdata), .iw_mem_ack(iw_mem_ack), .iw_mem_rdata(iw_mem_rdata),
      .ow_mem_err(ow_mem_err)
   );

   initial begin
      iw_clk = 1'b0;
      forever #5 iw_clk = ~iw_clk;
   end

   task automatic clear_inputs();
      iw_valid = 0; iw_flush = 0; iw_ready = 0; iw_mem_ack = 0; iw_mem_rdata = '0;
      iw_pc = '0; iw_instr = '0; iw_opc = '0; iw_result = '0; iw_src_data = '0;
      iw_tgt_gp = '0; iw_tgt_gp_we = 0; iw_tgt_sr = '0; iw_tgt_sr_we = 0;
   endtask

   task automatic drive_entry(input logic [7:0] opc, input logic [23:0] res, input logic [23:0] src,
                              input logic [3:0] gp, input logic gpwe, input logic [1:0] sr,
                              input logic srwe);
      iw_valid = 1; iw_opc = opc; iw_result = res; iw_src_data = src;
      iw_tgt_gp = gp; iw_tgt_gp_we = gpwe; iw_tgt_sr = sr; iw_tgt_sr_we = srwe;
      iw_pc = 24'($urandom); iw_instr = 24'($urandom);
   endtask

   task automatic do_reset();
      @(negedge iw_clk);
      iw_rst = 1;
      clear_inputs();
      repeat (2) @(negedge iw_clk);
      iw_rst = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ow_valid, ow_mem_req, ow_mem_err, ow_mem_we, ow_tgt_gp_we, ow_tgt_sr_we} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b exp 000000",
                  {ow_valid, ow_mem_req, ow_mem_err, ow_mem_we, ow_tgt_gp_we, ow_tgt_sr_we});
      end
      checks++;
      if ({ow_pc, ow_instr, ow_opc, ow_result, ow_mem_addr, ow_mem_wdata, ow_tgt_gp, ow_tgt_sr} !== '0) begin
         errors++;
         $display("FAIL reset_data: got pc=%h res=%h addr=%h exp all zero", ow_pc, ow_result, ow_mem_addr);
      end
      checks++;
      if (ow_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b exp 1", ow_ready);
      end
   endtask

   task automatic test_alu();
      logic [23:0] exp_res, exp_pc;
      logic [3:0]  exp_gp;
      @(negedge iw_clk);
      iw_ready = 1;
      exp_res = 24'h123456; exp_gp = 4'd3;
      drive_entry(8'h01, exp_res, 24'h0, exp_gp, 1'b1, 2'd0, 1'b0);
      exp_pc = iw_pc;
      for (int i = 1; i <= 4; i++) begin
         @(negedge iw_clk);
         checks++;
         if ({ow_valid, ow_tgt_gp_we, ow_tgt_gp, ow_result, ow_pc} !== {1'b1, 1'b1, exp_gp, exp_res, exp_pc}) begin
            errors++;
            $display("FAIL alu_b2b[%0d]: got v=%b we=%b gp=%h res=%h pc=%h exp 1 1 %h %h %h", i,
                     ow_valid, ow_tgt_gp_we, ow_tgt_gp, ow_result, ow_pc, exp_gp, exp_res, exp_pc);
         end
         if (i < 4) begin
            exp_res = 24'($urandom); exp_gp = 4'(i);
            drive_entry(8'h01, exp_res, 24'h0, exp_gp, 1'b1, 2'd0, 1'b0);
            exp_pc = iw_pc;
            #1;
            checks++;
            if (ow_ready !== 1'b1) begin
               errors++;
               $display("FAIL alu_ready[%0d]: got %b exp 1", i, ow_ready);
            end
         end else begin
            iw_valid = 0;
         end
      end
      @(negedge iw_clk);
      checks++;
      if ({ow_valid, ow_tgt_gp_we} !== 2'b00) begin
         errors++;
         $display("FAIL alu_drain: got v=%b we=%b exp 0 0", ow_valid, ow_tgt_gp_we);
      end
   endtask

   task automatic test_load();
      int nreq = 0;
      @(negedge iw_clk);
      iw_ready = 1;
      drive_entry(OPC_LD, 24'h000040, 24'h777777, 4'd5, 1'b1, 2'd1, 1'b1);
      @(negedge iw_clk);
      iw_valid = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ow_mem_req, ow_mem_we, ow_ready, ow_valid, ow_tgt_gp_we, ow_mem_addr} !==
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000040}) begin
            errors++;
            $display("FAIL ld_mem[%0d]: got req=%b we=%b rdy=%b v=%b gpwe=%b addr=%h exp 1 0 0 0 0 000040", i,
                     ow_mem_req, ow_mem_we, ow_ready, ow_valid, ow_tgt_gp_we, ow_mem_addr);
         end
         if (ow_mem_req === 1'b1) nreq++;
         iw_mem_ack   = (i == 2);
         iw_mem_rdata = (i == 2) ? 24'hABCDEF : 24'h0BAD00;
         @(negedge iw_clk);
      end
      iw_mem_ack = 0;
      checks++;
      if ({ow_mem_req, ow_valid, ow_result, ow_tgt_gp_we, ow_tgt_sr_we, 8'(nreq)} !==
          {1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b1, 8'd3}) begin
         errors++;
         $display("FAIL ld_done: got req=%b v=%b res=%h gpwe=%b srwe=%b nreq=%0d exp 0 1 abcdef 1 1 3",
                  ow_mem_req, ow_valid, ow_result, ow_tgt_gp_we, ow_tgt_sr_we, nreq);
      end
      @(negedge iw_clk);
      checks++;
      if (ow_valid !== 1'b0) begin
         errors++;
         $display("FAIL ld_drain: got v=%b exp 0", ow_valid);
      end
   endtask

   task automatic test_store();
      @(negedge iw_clk);
      iw_ready = 1;
      drive_entry(OPC_ST, 24'h000010, 24'h55AA55, 4'd2, 1'b0, 2'd1, 1'b1);
      @(negedge iw_clk);
      iw_valid = 0;
      checks++;
      if ({ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata} !== {1'b1, 1'b1, 24'h000010, 24'h55AA55}) begin
         errors++;
         $display("FAIL st_req: got req=%b we=%b addr=%h wd=%h exp 1 1 000010 55aa55",
                  ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata);
      end
      iw_mem_ack = 1; iw_mem_rdata = 24'hFFFFFF;
      @(negedge iw_clk);
      iw_mem_ack = 0;
      checks++;
      if ({ow_mem_req, ow_mem_we, ow_valid, ow_result, ow_tgt_sr_we} !== {1'b0, 1'b0, 1'b1, 24'h000010, 1'b1}) begin
         errors++;
         $display("FAIL st_done: got req=%b we=%b v=%b res=%h srwe=%b exp 0 0 1 000010 1",
                  ow_mem_req, ow_mem_we, ow_valid, ow_result, ow_tgt_sr_we);
      end
      @(negedge iw_clk);
   endtask

   task automatic test_timeout();
      int nreq = 0;
      int nerr = 0;
      @(negedge iw_clk);
      iw_ready = 1;
      drive_entry(OPC_LD, 24'h000200, 24'h0, 4'd7, 1'b1, 2'd3, 1'b1);
      @(negedge iw_clk);
      iw_valid = 0;
      while (ow_mem_req === 1'b1 && nreq < 40) begin
         nreq++;
         if (ow_mem_err === 1'b1) nerr++;
         @(negedge iw_clk);
      end
      checks++;
      if (nreq != TMO || nerr != 0) begin
         errors++;
         $display("FAIL tmo_cycles: got req cycles=%0d early errs=%0d exp %0d 0", nreq, nerr, TMO);
      end
      checks++;
      if ({ow_mem_err, ow_valid, ow_tgt_gp_we, ow_tgt_sr_we, ow_result} !== {1'b1, 1'b1, 1'b0, 1'b0, 24'h000200}) begin
         errors++;
         $display("FAIL tmo_err: got err=%b v=%b gpwe=%b srwe=%b res=%h exp 1 1 0 0 000200",
                  ow_mem_err, ow_valid, ow_tgt_gp_we, ow_tgt_sr_we, ow_result);
      end
      @(negedge iw_clk);
      checks++;
      if ({ow_mem_err, ow_valid, ow_mem_req} !== 3'b000) begin
         errors++;
         $display("FAIL tmo_after: got err=%b v=%b req=%b exp 0 0 0", ow_mem_err, ow_valid, ow_mem_req);
      end
   endtask

   task automatic test_hold_stall();
      logic [23:0] pc0, pc1;
      @(negedge iw_clk);
      iw_ready = 0;
      drive_entry(8'h05, 24'hABC123, 24'h0, 4'd9, 1'b1, 2'd2, 1'b1);
      pc0 = iw_pc;
      @(negedge iw_clk);
      for (int i = 0; i < 4; i++) begin
         drive_entry(8'h06, 24'h00F00D, 24'h0, 4'd1, 1'b1, 2'd0, 1'b0);
         #1;
         checks++;
         if ({ow_ready, ow_valid, ow_opc, ow_result, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we, ow_pc} !==
             {1'b0, 1'b1, 8'h05, 24'hABC123, 4'd9, 1'b1, 2'd2, 1'b1, pc0}) begin
            errors++;
            $display("FAIL hold_stall[%0d]: got rdy=%b v=%b opc=%h res=%h pc=%h exp 0 1 05 abc123 %h", i,
                     ow_ready, ow_valid, ow_opc, ow_result, ow_pc, pc0);
         end
         @(negedge iw_clk);
      end
      pc1 = iw_pc;
      iw_ready = 1;
      #1;
      checks++;
      if (ow_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release_ready: got %b exp 1", ow_ready);
      end
      @(negedge iw_clk);
      iw_valid = 0;
      checks++;
      if ({ow_valid, ow_opc, ow_result, ow_pc, ow_tgt_sr_we} !== {1'b1, 8'h06, 24'h00F00D, pc1, 1'b0}) begin
         errors++;
         $display("FAIL hold_next: got v=%b opc=%h res=%h pc=%h exp 1 06 00f00d %h",
                  ow_valid, ow_opc, ow_result, ow_pc, pc1);
      end
      @(negedge iw_clk);
   endtask

   task automatic test_flush_mem();
      @(negedge iw_clk);
      iw_ready = 1;
      drive_entry(OPC_LD, 24'h000300, 24'h0, 4'd4, 1'b1, 2'd1, 1'b1);
      @(negedge iw_clk);
      iw_valid = 0;
      @(negedge iw_clk);
      iw_flush = 1; iw_mem_ack = 1; iw_mem_rdata = 24'hDEAD01;
      @(negedge iw_clk);
      iw_flush = 0; iw_mem_ack = 0;
      #1;
      checks++;
      if ({ow_valid, ow_mem_req, ow_mem_err, ow_tgt_gp_we, ow_ready} !== 5'b00001 || ow_result === 24'hDEAD01) begin
         errors++;
         $display("FAIL flush_mem: got v=%b req=%b err=%b gpwe=%b rdy=%b res=%h exp 0 0 0 0 1 (res not dead01)",
                  ow_valid, ow_mem_req, ow_mem_err, ow_tgt_gp_we, ow_ready, ow_result);
      end
      @(negedge iw_clk);
      checks++;
      if ({ow_valid, ow_mem_req} !== 2'b00) begin
         errors++;
         $display("FAIL flush_after: got v=%b req=%b exp 0 0", ow_valid, ow_mem_req);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge iw_clk);
      iw_ready = 0;
      drive_entry(8'h07, 24'h654321, 24'h111111, 4'hF, 1'b1, 2'd3, 1'b1);
      @(negedge iw_clk);
      iw_valid = 0;
      iw_rst = 1;
      @(negedge iw_clk);
      iw_rst = 0;
      checks++;
      if ({ow_valid, ow_tgt_gp_we, ow_tgt_sr_we, ow_pc, ow_instr, ow_opc, ow_result, ow_tgt_gp, ow_tgt_sr} !== '0) begin
         errors++;
         $display("FAIL reset_hold: got v=%b gpwe=%b opc=%h res=%h gp=%h exp all zero",
                  ow_valid, ow_tgt_gp_we, ow_opc, ow_result, ow_tgt_gp);
      end
      iw_ready = 1;
      drive_entry(OPC_LD, 24'h000500, 24'h0, 4'd1, 1'b1, 2'd0, 1'b0);
      @(negedge iw_clk);
      iw_valid = 0;
      checks++;
      if (ow_mem_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_mem_pre: got req=%b exp 1", ow_mem_req);
      end
      iw_rst = 1;
      @(negedge iw_clk);
      iw_rst = 0;
      checks++;
      if ({ow_mem_req, ow_valid, ow_mem_addr} !== {1'b0, 1'b0, 24'h0}) begin
         errors++;
         $display("FAIL reset_mem: got req=%b v=%b addr=%h exp 0 0 000000", ow_mem_req, ow_valid, ow_mem_addr);
      end
   endtask

   // Transaction-level model: one entry at most; memory ops occupy a fixed number of request cycles.
   task automatic test_random();
      ent_t        cur;
      bit          occupied = 0;
      bit          tmo = 0;
      bit          err_exp = 0;
      int          mem_left = 0;
      int          req_idx = 0;
      int          lat = 0;
      logic [23:0] rd_data = '0;
      logic [7:0]  opc;
      bit          valid_exp, req_exp, ready_exp, acc;
      logic [1:0]  we_exp;
      do_reset();
      for (int cyc = 0; cyc < 3000 && errors < 50; cyc++) begin
         @(negedge iw_clk);
         iw_ready = ($urandom_range(0, 3) != 0);
         iw_flush = ($urandom_range(0, 31) == 0);
         iw_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 2))
            0:       opc = OPC_LD;
            1:       opc = OPC_ST;
            default: opc = 8'($urandom_range(0, 255));
         endcase
         iw_opc = opc; iw_pc = 24'($urandom); iw_instr = 24'($urandom);
         iw_result = 24'($urandom); iw_src_data = 24'($urandom);
         iw_tgt_gp = 4'($urandom); iw_tgt_gp_we = 1'($urandom);
         iw_tgt_sr = 2'($urandom); iw_tgt_sr_we = 1'($urandom);
         req_exp   = (mem_left > 0);
         valid_exp = occupied && (mem_left == 0);
         ready_exp = !occupied || (valid_exp && iw_ready);
         if (req_exp) begin
            iw_mem_ack   = (req_idx == lat);
            iw_mem_rdata = (req_idx == lat) ? rd_data : 24'($urandom);
         end else begin
            iw_mem_ack   = ($urandom_range(0, 3) == 0);
            iw_mem_rdata = 24'($urandom);
         end
         #1;
         checks++;
         if ({ow_valid, ow_mem_req, ow_mem_err, ow_ready} !== {valid_exp, req_exp, err_exp, ready_exp}) begin
            errors++;
            $display("FAIL rnd_ctrl[%0d]: got v=%b req=%b err=%b rdy=%b exp %b %b %b %b", cyc,
                     ow_valid, ow_mem_req, ow_mem_err, ow_ready, valid_exp, req_exp, err_exp, ready_exp);
         end
         we_exp = valid_exp ? {cur.gp_we, cur.sr_we} : 2'b00;
         checks++;
         if ({ow_tgt_gp_we, ow_tgt_sr_we} !== we_exp) begin
            errors++;
            $display("FAIL rnd_we[%0d]: got %b%b exp %b", cyc, ow_tgt_gp_we, ow_tgt_sr_we, we_exp);
         end
         if (valid_exp) begin
            checks++;
            if ({ow_pc, ow_instr, ow_opc, ow_result, ow_tgt_gp, ow_tgt_sr} !==
                {cur.pc, cur.instr, cur.opc, cur.result, cur.gp, cur.sr}) begin
               errors++;
               $display("FAIL rnd_fields[%0d]: got pc=%h opc=%h res=%h gp=%h sr=%h exp %h %h %h %h %h", cyc,
                        ow_pc, ow_opc, ow_result, ow_tgt_gp, ow_tgt_sr, cur.pc, cur.opc, cur.result, cur.gp, cur.sr);
            end
         end
         if (req_exp) begin
            checks++;
            if ({ow_mem_we, ow_mem_addr, ow_mem_wdata} !== {cur.is_st, cur.addr, cur.wdata}) begin
               errors++;
               $display("FAIL rnd_req[%0d]: got we=%b addr=%h wd=%h exp %b %h %h", cyc,
                        ow_mem_we, ow_mem_addr, ow_mem_wdata, cur.is_st, cur.addr, cur.wdata);
            end
         end
         acc = iw_valid && ready_exp && !iw_flush;
         err_exp = 0;
         if (iw_flush) begin
            occupied = 0;
            mem_left = 0;
         end else begin
            if (valid_exp && iw_ready) occupied = 0;
            if (mem_left > 0) begin
               mem_left--;
               req_idx++;
               if (mem_left == 0 && tmo) err_exp = 1;
            end
         end
         if (acc) begin
            cur.pc = iw_pc; cur.instr = iw_instr; cur.opc = iw_opc; cur.result = iw_result;
            cur.addr = iw_result; cur.wdata = iw_src_data; cur.gp = iw_tgt_gp; cur.gp_we = iw_tgt_gp_we;
            cur.sr = iw_tgt_sr; cur.sr_we = iw_tgt_sr_we; cur.is_st = (iw_opc == OPC_ST);
            occupied = 1;
            mem_left = 0;
            if (iw_opc == OPC_LD || iw_opc == OPC_ST) begin
               lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO, TMO + 5)) : int'($urandom_range(0, 5));
               rd_data = 24'($urandom);
               req_idx = 0;
               tmo = (lat >= int'(TMO));
               if (tmo) begin
                  mem_left = TMO;
                  cur.gp_we = 0;
                  cur.sr_we = 0;
               end else begin
                  mem_left = lat + 1;
                  if (!cur.is_st) cur.result = rd_data;
               end
            end
         end
      end
   endtask

   initial begin
      clear_inputs();
      iw_rst = 1;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_hold_stall();
      test_flush_mem();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: got timeout exp completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
